// File: rtl/chip8_sprite_blitter.sv
// CHIP-8 / SUPER-CHIP sprite blitter: XORs 8xN or 16x16 sprites into a 1-bpp
// screen held in shared RAM, with per-draw wrap/clip and collision reporting.
module chip8_sprite_blitter #(
  parameter int W_BYTES = 8,
  parameter int H = 32,
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] SCREEN_BASE = ADDR_W'('h100),
  localparam int XW = $clog2(W_BYTES*8),
  localparam int YW = $clog2(H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              draw,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        sprite_height,
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  logic              wide,
  input  logic              wrap,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic [4:0]        collision_rows,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic              mem_read_enable,
  input  logic [7:0]        mem_read_data,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [7:0]        mem_write_data,
  output logic              mem_write_enable
);
  localparam int CW = XW - 3;

  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, RD, RMW, NEXT} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] base;
  logic [3:0]        height;
  logic [CW-1:0]     xb;
  logic [2:0]        shift;
  logic [YW-1:0]     y_q;
  logic              wide_q, wrap_q;
  logic [4:0]        row, row_n;
  logic [1:0]        k;
  logic [7:0]        b0, b1;
  logic              row_hit;

  logic [4:0]        rows_total, clipped;
  logic              row_last, row_term, finish, k_more, start_empty;
  logic [1:0]        n_bytes;
  logic [YW-1:0]     r_idx;
  logic [CW-1:0]     c_idx;
  logic [31:0]       scr_sum;
  logic [ADDR_W-1:0] scr_addr;
  logic [23:0]       span;
  logic [7:0]        p;
  logic [5:0]        cr_sum;

  assign start_empty = !wide && (sprite_height == 4'd0);
  assign rows_total  = wide_q ? 5'd16 : {1'b0, height};
  assign row_n       = row + 5'd1;
  assign row_last    = (row_n == rows_total);
  assign row_term    = !wrap_q && (int'(y_q) + int'(row) + 1 >= H);
  assign finish      = row_last || row_term;
  assign n_bytes     = wide_q ? ((shift != 3'd0) ? 2'd3 : 2'd2)
                              : ((shift != 3'd0) ? 2'd2 : 2'd1);
  // Clipped bytes are always the trailing ones, so stopping at the first is enough.
  assign k_more      = (int'(k) + 1 < int'(n_bytes)) &&
                       (wrap_q || (int'(xb) + int'(k) + 1 < W_BYTES));

  // Natural truncation of the row/column sums gives the wrap-mode modulo.
  assign r_idx    = y_q + YW'(row);
  assign c_idx    = xb + CW'(k);
  assign scr_sum  = 32'(SCREEN_BASE) + (32'(r_idx) << CW) + 32'(c_idx);
  assign scr_addr = scr_sum[ADDR_W-1:0];

  assign span = wide_q ? ({b0, b1, 8'h00} >> shift) : ({b0, 16'h0000} >> shift);
  always_comb begin
    case (k)
      2'd0:    p = span[23:16];
      2'd1:    p = span[15:8];
      default: p = span[7:0];
    endcase
  end

  // Rows left undrawn by a clip count toward collision_rows.
  assign clipped = (row_term && !row_last) ? (rows_total - row_n) : 5'd0;
  assign cr_sum  = {1'b0, collision_rows} + {5'd0, row_hit} + {1'b0, clipped};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (draw && !start_empty) state_nxt = FETCH0;
      FETCH0:  state_nxt = wide_q ? FETCH1 : RD;
      FETCH1:  state_nxt = RD;
      RD:      state_nxt = RMW;
      RMW:     state_nxt = k_more ? RD : NEXT;
      NEXT:    state_nxt = finish ? IDLE : FETCH0;
      default: state_nxt = IDLE;
    endcase
  end

  // Enables are gated by reset so an abort stops memory traffic at once.
  always_comb begin
    busy              = (state != IDLE);
    mem_read_enable   = 1'b0;
    mem_read_address  = '0;
    mem_write_enable  = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;
    if (!reset) begin
      case (state)
        IDLE: if (draw && !start_empty) begin
          mem_read_enable  = 1'b1;
          mem_read_address = address;
        end
        FETCH0: if (wide_q) begin
          mem_read_enable  = 1'b1;
          mem_read_address = base + ADDR_W'({row, 1'b1});
        end
        RD: begin
          mem_read_enable  = 1'b1;
          mem_read_address = scr_addr;
        end
        RMW: begin
          mem_write_enable  = 1'b1;
          mem_write_address = scr_addr;
          mem_write_data    = mem_read_data ^ p;
        end
        NEXT: if (!finish) begin
          mem_read_enable  = 1'b1;
          mem_read_address = wide_q ? base + ADDR_W'({row_n, 1'b0}) : base + ADDR_W'(row_n);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0; collision <= 1'b0; collision_rows <= '0;
      base <= '0; height <= '0; xb <= '0; shift <= '0; y_q <= '0;
      wide_q <= 1'b0; wrap_q <= 1'b0; row <= '0; k <= '0;
      b0 <= '0; b1 <= '0; row_hit <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (draw) begin
          base <= address; height <= sprite_height;
          xb <= x[XW-1:3]; shift <= x[2:0]; y_q <= y;
          wide_q <= wide; wrap_q <= wrap;
          row <= '0; k <= '0; row_hit <= 1'b0;
          collision <= 1'b0; collision_rows <= '0;
          done <= start_empty;
        end
        FETCH0: begin
          b0 <= mem_read_data; k <= '0; row_hit <= 1'b0;
        end
        FETCH1: b1 <= mem_read_data;
        RMW: begin
          if (|(mem_read_data & p)) begin
            collision <= 1'b1; row_hit <= 1'b1;
          end
          k <= k + 2'd1;
        end
        NEXT: begin
          collision_rows <= (cr_sum > 6'd16) ? 5'd16 : cr_sum[4:0];
          if (finish) done <= 1'b1;
          else        row  <= row_n;
        end
        default: ;
      endcase
    end
  end
endmodule
